// File: rtl/pipe_run_monitor_pkg.sv
// Shared definitions for the pipelined-core run monitor: state encoding,
// flag bit positions and the default termination signature.
package run_mon_pkg;

  typedef enum logic [1:0] {
    ST_LOAD = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } run_state_e;

  // Bit positions inside the 4-bit sticky flags vector.
  localparam int FLAG_EXP_OVF   = 0;
  localparam int FLAG_LEFTOVER  = 1;
  localparam int FLAG_UNDERFLOW = 2;
  localparam int FLAG_TIMEOUT   = 3;

  localparam logic [31:0] TERM_SIG_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/pipe_run_monitor_if.sv
// Observation bus from the core: data-memory write port plus fetched instruction.
interface pipe_run_monitor_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) ();
  logic              mon_write;
  logic [ADDR_W-1:0] mon_addr;
  logic [DATA_W-1:0] mon_data;
  logic [DATA_W-1:0] mon_inst;

  modport master (output mon_write, output mon_addr, output mon_data, output mon_inst);
  modport slave  (input  mon_write, input  mon_addr, input  mon_data, input  mon_inst);
endinterface

// File: rtl/pipe_run_monitor_fifo.sv
// Single-clock expected-answer FIFO; pointers carry an extra wrap bit so that
// full and empty are distinguished without a separate occupancy counter.
module mon_exp_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              push_ok, pop_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head    = mem_q[rd_ptr_q[AW-1:0]];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = {(AW+1){1'b0}};
      rd_ptr_d = {(AW+1){1'b0}};
    end else begin
      wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q <= {(AW+1){1'b0}};
      rd_ptr_q <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end
endmodule

// File: rtl/pipe_run_monitor.sv
// Run monitor: checks committed data writes against a preloaded answer list,
// counts run cycles and fetch-stall episodes, and reports a pass/fail verdict.
module pipe_run_monitor
  import run_mon_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                EXP_DEPTH   = 64,
  parameter logic [DATA_W-1:0] TERM_SIG    = {DATA_W{1'b1}},
  parameter int                STALL_LIMIT = 2,
  parameter int unsigned       TIMEOUT     = 32'd1_000_000,
  parameter int                CNT_W       = 32
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               exp_wr_en,
  input  logic [DATA_W-1:0]  exp_wr_data,
  input  logic               arm,
  pipe_run_monitor_if.slave  mon,
  output logic [1:0]         state_o,
  output logic               done,
  output logic               pass,
  output logic [CNT_W-1:0]   match_cnt,
  output logic [CNT_W-1:0]   mismatch_cnt,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic               err_valid,
  output logic [ADDR_W-1:0]  err_addr,
  output logic [DATA_W-1:0]  err_exp,
  output logic [DATA_W-1:0]  err_act,
  output logic [3:0]         flags
);
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] STALL_RUN   = CNT_W'(STALL_LIMIT - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  run_state_e        state_q, state_d;
  logic [CNT_W-1:0]  match_cnt_q, match_cnt_d, mismatch_cnt_q, mismatch_cnt_d;
  logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d, stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  run_len_q, run_len_d, cycle_inc;
  logic              err_valid_q, err_valid_d, done_q, done_d, pass_q, pass_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic [DATA_W-1:0] err_exp_q, err_exp_d, err_act_q, err_act_d;
  logic [DATA_W-1:0] prev_inst_q, prev_inst_d;
  logic [3:0]        flags_q, flags_d;
  logic              fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty, term_hit;
  logic [DATA_W-1:0] fifo_head;

  mon_exp_fifo #(.DATA_W(DATA_W), .DEPTH(EXP_DEPTH)) u_fifo (
    .clk(clk), .nrst(nrst), .push(fifo_push), .pop(fifo_pop), .flush(fifo_flush),
    .din(exp_wr_data), .full(fifo_full), .empty(fifo_empty), .head(fifo_head)
  );

  assign term_hit  = mon.mon_write && (mon.mon_data == TERM_SIG);
  assign cycle_inc = sat_inc(cycle_cnt_q);

  always_comb begin
    state_d = state_q;           match_cnt_d = match_cnt_q;   mismatch_cnt_d = mismatch_cnt_q;
    cycle_cnt_d = cycle_cnt_q;   stall_cnt_d = stall_cnt_q;   run_len_d = run_len_q;
    err_valid_d = err_valid_q;   err_addr_d = err_addr_q;     err_exp_d = err_exp_q;
    err_act_d = err_act_q;       prev_inst_d = prev_inst_q;   flags_d = flags_q;
    fifo_push = 1'b0;            fifo_pop = 1'b0;             fifo_flush = 1'b0;
    case (state_q)
      ST_LOAD: begin
        fifo_push = exp_wr_en;
        flags_d[FLAG_EXP_OVF] = flags_q[FLAG_EXP_OVF] | (exp_wr_en & fifo_full);
        // Arming keeps the loaded answers and the load-phase overflow flag.
        if (arm) begin
          state_d = ST_RUN;
          match_cnt_d = CNT_ZERO;  mismatch_cnt_d = CNT_ZERO;
          cycle_cnt_d = CNT_ZERO;  stall_cnt_d = CNT_ZERO;  run_len_d = CNT_ZERO;
          err_valid_d = 1'b0;      err_addr_d = {ADDR_W{1'b0}};
          err_exp_d = {DATA_W{1'b0}};  err_act_d = {DATA_W{1'b0}};
          prev_inst_d = {DATA_W{1'b0}};
          flags_d[FLAG_TIMEOUT] = 1'b0;  flags_d[FLAG_UNDERFLOW] = 1'b0;
          flags_d[FLAG_LEFTOVER] = 1'b0;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_RUN: begin
        cycle_cnt_d = cycle_inc;
        prev_inst_d = mon.mon_inst;
        if (mon.mon_inst == prev_inst_q) begin
          run_len_d   = (run_len_q == STALL_RUN) ? run_len_q : run_len_q + CNT_ONE;
          stall_cnt_d = (run_len_q == STALL_RUN - CNT_ONE) ? sat_inc(stall_cnt_q) : stall_cnt_q;
        end else begin
          run_len_d = CNT_ZERO;
        end
        if (term_hit) begin
          state_d = ST_DONE;
          flags_d[FLAG_LEFTOVER] = ~fifo_empty;
        end else begin
          if (mon.mon_write) begin
            fifo_pop = 1'b1;
            if (!fifo_empty && (fifo_head == mon.mon_data)) begin
              match_cnt_d = sat_inc(match_cnt_q);
            end else begin
              mismatch_cnt_d = sat_inc(mismatch_cnt_q);
              flags_d[FLAG_UNDERFLOW] = flags_q[FLAG_UNDERFLOW] | fifo_empty;
              if (!err_valid_q) begin
                err_valid_d = 1'b1;
                err_addr_d  = mon.mon_addr;
                err_exp_d   = fifo_empty ? {DATA_W{1'b0}} : fifo_head;
                err_act_d   = mon.mon_data;
              end else begin
                err_valid_d = 1'b1;
              end
            end
          end else begin
            fifo_pop = 1'b0;
          end
          if (cycle_inc == TIMEOUT_CNT) begin
            flags_d[FLAG_TIMEOUT] = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_DONE: begin
        if (arm) begin
          state_d = ST_LOAD;
          fifo_flush = 1'b1;
          flags_d[FLAG_EXP_OVF] = 1'b0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_LOAD;
    endcase
    done_d = (state_d == ST_DONE);
    pass_d = done_d && (mismatch_cnt_d == CNT_ZERO) && (flags_d == 4'b0000);
  end

  // State, counters, error capture and verdict registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_LOAD;         match_cnt_q <= CNT_ZERO;     mismatch_cnt_q <= CNT_ZERO;
      cycle_cnt_q <= CNT_ZERO;    stall_cnt_q <= CNT_ZERO;     run_len_q <= CNT_ZERO;
      err_valid_q <= 1'b0;        err_addr_q <= {ADDR_W{1'b0}};
      err_exp_q <= {DATA_W{1'b0}};  err_act_q <= {DATA_W{1'b0}};
      prev_inst_q <= {DATA_W{1'b0}};  flags_q <= 4'b0000;
      done_q <= 1'b0;             pass_q <= 1'b0;
    end else begin
      state_q <= state_d;         match_cnt_q <= match_cnt_d;  mismatch_cnt_q <= mismatch_cnt_d;
      cycle_cnt_q <= cycle_cnt_d; stall_cnt_q <= stall_cnt_d;  run_len_q <= run_len_d;
      err_valid_q <= err_valid_d; err_addr_q <= err_addr_d;
      err_exp_q <= err_exp_d;     err_act_q <= err_act_d;
      prev_inst_q <= prev_inst_d; flags_q <= flags_d;
      done_q <= done_d;           pass_q <= pass_d;
    end
  end

  assign state_o      = state_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign match_cnt    = match_cnt_q;
  assign mismatch_cnt = mismatch_cnt_q;
  assign cycle_cnt    = cycle_cnt_q;
  assign stall_cnt    = stall_cnt_q;
  assign err_valid    = err_valid_q;
  assign err_addr     = err_addr_q;
  assign err_exp      = err_exp_q;
  assign err_act      = err_act_q;
  assign flags        = flags_q;
endmodule

// File: tb/tb_pipe_run_monitor.sv
// Bench for pipe_run_monitor: directed scenario table, hand-written corner
// sequences and randomized runs, all checked against a queue-based model.
module tb_pipe_run_monitor;
  import run_mon_pkg::*;

  localparam int DEPTH = 8;
  localparam int TOUT  = 100;
  localparam int STALL = 2;

  logic        clk = 1'b0;
  logic        nrst;
  logic        exp_wr_en, arm;
  logic [31:0] exp_wr_data;
  logic [1:0]  state_o;
  logic        done, pass, err_valid;
  logic [31:0] match_cnt, mismatch_cnt, cycle_cnt, stall_cnt, err_addr, err_exp, err_act;
  logic [3:0]  flags;

  pipe_run_monitor_if #(.DATA_W(32), .ADDR_W(32)) mon_if ();

  pipe_run_monitor #(
    .DATA_W(32), .ADDR_W(32), .EXP_DEPTH(DEPTH), .TERM_SIG(TERM_SIG_DEFAULT),
    .STALL_LIMIT(STALL), .TIMEOUT(TOUT), .CNT_W(32)
  ) dut (
    .clk(clk), .nrst(nrst), .exp_wr_en(exp_wr_en), .exp_wr_data(exp_wr_data), .arm(arm),
    .mon(mon_if), .state_o(state_o), .done(done), .pass(pass),
    .match_cnt(match_cnt), .mismatch_cnt(mismatch_cnt), .cycle_cnt(cycle_cnt),
    .stall_cnt(stall_cnt), .err_valid(err_valid), .err_addr(err_addr),
    .err_exp(err_exp), .err_act(err_act), .flags(flags)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: mode 0 load, 1 run, 2 done; answers held in a queue.
  logic [1:0]  m_state;
  logic [31:0] m_q[$];
  logic [31:0] m_match, m_mis, m_cycle, m_stall, m_prev, m_eaddr, m_eexp, m_eact;
  logic        m_ev;
  logic [3:0]  m_flags;
  int          m_run;
  logic [31:0] inst_ctr = 32'h0000_1000;

  typedef struct {
    int          n_load;
    logic [2:0][31:0] ld;
    int          n_wr;
    logic [2:0][31:0] wr;
    logic [31:0] e_match, e_mis;
    logic        e_pass;
    logic [3:0]  e_flags;
    logic        e_ev;
    logic [31:0] e_addr, e_exp, e_act;
  } scen_t;

  scen_t sc[4];

  function automatic scen_t mk(input int nl, input logic [31:0] l0, l1, l2,
                               input int nw, input logic [31:0] w0, w1, w2,
                               input logic [31:0] em, emis, input logic ep,
                               input logic [3:0] ef, input logic ev,
                               input logic [31:0] ea, ee, eact);
    scen_t s;
    s.n_load = nl; s.ld[0] = l0; s.ld[1] = l1; s.ld[2] = l2;
    s.n_wr = nw;   s.wr[0] = w0; s.wr[1] = w1; s.wr[2] = w2;
    s.e_match = em; s.e_mis = emis; s.e_pass = ep; s.e_flags = ef;
    s.e_ev = ev; s.e_addr = ea; s.e_exp = ee; s.e_act = eact;
    return s;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 2'd0; m_q.delete();
    m_match = 32'd0; m_mis = 32'd0; m_cycle = 32'd0; m_stall = 32'd0; m_prev = 32'd0;
    m_ev = 1'b0; m_eaddr = 32'd0; m_eexp = 32'd0; m_eact = 32'd0; m_flags = 4'd0; m_run = 0;
  endtask

  task automatic capture(input logic [31:0] a, input logic [31:0] e, input logic [31:0] d);
    m_mis = m_mis + 32'd1;
    if (!m_ev) begin
      m_ev = 1'b1; m_eaddr = a; m_eexp = e; m_eact = d;
    end
  endtask

  task automatic model_step();
    logic [31:0] hd;
    case (m_state)
      2'd0: begin
        if (exp_wr_en) begin
          if (m_q.size() < DEPTH) m_q.push_back(exp_wr_data);
          else m_flags[0] = 1'b1;
        end
        if (arm) begin
          m_state = 2'd1; m_match = 32'd0; m_mis = 32'd0; m_cycle = 32'd0; m_stall = 32'd0;
          m_flags[3:1] = 3'd0; m_ev = 1'b0; m_eaddr = 32'd0; m_eexp = 32'd0; m_eact = 32'd0;
          m_prev = 32'd0; m_run = 0;
        end
      end
      2'd1: begin
        m_cycle = m_cycle + 32'd1;
        if (mon_if.mon_inst == m_prev) begin
          m_run++;
          if (m_run == STALL - 1) m_stall = m_stall + 32'd1;
        end else m_run = 0;
        m_prev = mon_if.mon_inst;
        if (mon_if.mon_write && mon_if.mon_data == TERM_SIG_DEFAULT) begin
          m_state = 2'd2;
          m_flags[1] = (m_q.size() != 0);
        end else begin
          if (mon_if.mon_write) begin
            if (m_q.size() == 0) begin
              m_flags[2] = 1'b1;
              capture(mon_if.mon_addr, 32'd0, mon_if.mon_data);
            end else begin
              hd = m_q.pop_front();
              if (hd == mon_if.mon_data) m_match = m_match + 32'd1;
              else capture(mon_if.mon_addr, hd, mon_if.mon_data);
            end
          end
          if (m_cycle == TOUT) begin
            m_flags[3] = 1'b1; m_state = 2'd2;
          end
        end
      end
      default: begin
        if (arm) begin
          m_state = 2'd0; m_q.delete(); m_flags[0] = 1'b0;
        end
      end
    endcase
  endtask

  task automatic check_all();
    logic m_pass;
    m_pass = (m_state == 2'd2) && (m_mis == 32'd0) && (m_flags == 4'd0);
    chk("state", 32'(state_o), 32'(m_state));
    chk("done", 32'(done), 32'(m_state == 2'd2));
    chk("pass", 32'(pass), 32'(m_pass));
    chk("match_cnt", match_cnt, m_match);
    chk("mismatch_cnt", mismatch_cnt, m_mis);
    chk("cycle_cnt", cycle_cnt, m_cycle);
    chk("stall_cnt", stall_cnt, m_stall);
    chk("err_valid", 32'(err_valid), 32'(m_ev));
    chk("err_addr", err_addr, m_eaddr);
    chk("err_exp", err_exp, m_eexp);
    chk("err_act", err_act, m_eact);
    chk("flags", 32'(flags), 32'(m_flags));
  endtask

  task automatic drv(input logic we, input logic [31:0] wd, input logic a,
                     input logic mw, input logic [31:0] ma, input logic [31:0] md);
    exp_wr_en = we; exp_wr_data = wd; arm = a;
    mon_if.mon_write = mw; mon_if.mon_addr = ma; mon_if.mon_data = md;
    mon_if.mon_inst = inst_ctr;
    inst_ctr = inst_ctr + 32'd4;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle();
    drv(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
  endtask

  task automatic pulse_arm();
    drv(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0);
    tick();
  endtask

  task automatic term_write();
    drv(1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_0040, TERM_SIG_DEFAULT);
    tick();
  endtask

  task automatic run_scen(input int k);
    scen_t s;
    s = sc[k];
    if (m_state == 2'd2) pulse_arm();
    for (int i = 0; i < s.n_load; i++) begin
      drv(1'b1, s.ld[i], 1'b0, 1'b0, 32'd0, 32'd0);
      tick();
    end
    pulse_arm();
    for (int i = 0; i < s.n_wr; i++) begin
      drv(1'b0, 32'd0, 1'b0, 1'b1, 32'h10 + 32'(4 * i), s.wr[i]);
      tick();
    end
    term_write();
    idle();
    chk("tbl_done", 32'(done), 32'd1);
    chk("tbl_match", match_cnt, s.e_match);
    chk("tbl_mismatch", mismatch_cnt, s.e_mis);
    chk("tbl_pass", 32'(pass), 32'(s.e_pass));
    chk("tbl_flags", 32'(flags), 32'(s.e_flags));
    chk("tbl_err_valid", 32'(err_valid), 32'(s.e_ev));
    chk("tbl_err_addr", err_addr, s.e_addr);
    chk("tbl_err_exp", err_exp, s.e_exp);
    chk("tbl_err_act", err_act, s.e_act);
  endtask

  initial begin
    sc[0] = mk(3, 32'hA5A5_0001, 32'h0000_0010, 32'hDEAD_BEEF,
               3, 32'hA5A5_0001, 32'h0000_0010, 32'hDEAD_BEEF,
               32'd3, 32'd0, 1'b1, 4'b0000, 1'b0, 32'd0, 32'd0, 32'd0);
    sc[1] = mk(3, 32'hA5A5_0001, 32'h0000_0010, 32'hDEAD_BEEF,
               3, 32'hA5A5_0001, 32'h0000_0011, 32'hDEAD_BEEF,
               32'd2, 32'd1, 1'b0, 4'b0000, 1'b1, 32'h14, 32'h10, 32'h11);
    sc[2] = mk(1, 32'h0000_0055, 32'd0, 32'd0,
               2, 32'h0000_0055, 32'h0000_0066, 32'd0,
               32'd1, 32'd1, 1'b0, 4'b0100, 1'b1, 32'h14, 32'h0, 32'h66);
    sc[3] = mk(3, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003,
               2, 32'h0000_0001, 32'h0000_0002, 32'd0,
               32'd2, 32'd0, 1'b0, 4'b0010, 1'b0, 32'd0, 32'd0, 32'd0);

    nrst = 1'b0;
    drv(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    model_reset();
    #2;
    check_all();
    #8 nrst = 1'b1;

    for (int k = 0; k < 4; k++) run_scen(k);

    // Stall episodes: one long hold, then two short holds.
    pulse_arm();
    pulse_arm();
    idle();
    for (int i = 0; i < 5; i++) begin
      drv(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
      mon_if.mon_inst = 32'h2002_0004;
      tick();
    end
    idle();
    chk("stall_long_hold", stall_cnt, 32'd1);
    for (int i = 0; i < 6; i++) begin
      drv(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
      mon_if.mon_inst = (i < 2) ? 32'h3000_0000 : ((i == 2) ? 32'h3000_0008 : 32'h3000_0010);
      if (i == 5) mon_if.mon_inst = 32'h3000_0014;
      tick();
    end
    chk("stall_two_holds", stall_cnt, 32'd3);
    term_write();

    // Timeout without termination.
    pulse_arm();
    pulse_arm();
    for (int i = 1; i <= TOUT; i++) begin
      idle();
      if (i == TOUT - 1) chk("tout_still_run", 32'(state_o), 32'(ST_RUN));
    end
    chk("tout_state", 32'(state_o), 32'(ST_DONE));
    chk("tout_cycles", cycle_cnt, 32'd100);
    chk("tout_flag", 32'(flags), 32'b1000);

    // Termination on the timeout cycle wins.
    pulse_arm();
    pulse_arm();
    for (int i = 1; i < TOUT; i++) idle();
    term_write();
    chk("term_on_tout_flags", 32'(flags), 32'd0);
    chk("term_on_tout_cycles", cycle_cnt, 32'd100);
    chk("term_on_tout_pass", 32'(pass), 32'd1);

    // Overflow of the answer buffer, then reset in the middle of a run.
    pulse_arm();
    for (int i = 0; i <= DEPTH; i++) begin
      drv(1'b1, 32'(i), 1'b0, 1'b0, 32'd0, 32'd0);
      tick();
    end
    chk("exp_ovf", 32'(flags[0]), 32'd1);
    pulse_arm();
    drv(1'b0, 32'd0, 1'b0, 1'b1, 32'h10, 32'd0);
    tick();
    drv(1'b0, 32'd0, 1'b0, 1'b1, 32'h14, 32'd7);
    tick();
    #2 nrst = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("rst_state_load", 32'(state_o), 32'(ST_LOAD));
    #3 nrst = 1'b1;

    // Randomized runs against the model.
    for (int r = 0; r < 25; r++) begin
      int nl;
      if (m_state == 2'd2) pulse_arm();
      nl = $urandom_range(0, DEPTH + 1);
      for (int i = 0; i < nl; i++) begin
        drv(1'b1, 32'($urandom_range(0, 3)), 1'b0, 1'($urandom_range(0, 1)),
            32'($urandom), 32'($urandom));
        tick();
      end
      pulse_arm();
      for (int c = 0; c < 130 && m_state == 2'd1; c++) begin
        logic [31:0] md;
        md = (m_q.size() > 0 && $urandom_range(0, 3) != 0) ? m_q[0] : 32'($urandom_range(0, 3));
        if ($urandom_range(0, 39) == 0) md = TERM_SIG_DEFAULT;
        drv(1'($urandom_range(0, 1)), 32'($urandom), 1'($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 2) == 0), 32'($urandom), md);
        mon_if.mon_inst = 32'($urandom_range(0, 2) * 4);
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pipe_run_monitor.md
Name: pipe_run_monitor

Overview:
- Synthesizable run monitor for the pipelined processor; sits beside the core on the data-memory write port and instruction bus, usable on FPGA or in simulation.
- Preloaded with expected store values; compares each committed data write in order, stops on a termination signature or timeout, counts cycles and reports PC stall episodes.
- Generalises checking to parametrised width, answer depth, termination value, stall threshold and timeout, with sticky error capture and a pass/fail verdict.

Parameters:
- DATA_W, 32, data/instruction width
- ADDR_W, 32, data address width
- EXP_DEPTH, 64, expected-answer buffer entries (power of 2)
- TERM_SIG, all-ones (DATA_W), write value that ends the run
- STALL_LIMIT, 2, consecutive identical-instruction cycles that count as a stall episode (>=2)
- TIMEOUT, 32'd1_000_000, run-cycle limit
- CNT_W, 32, counter width

Ports:
- clk  in  1  clock, rising edge
- nrst  in  1  reset, asynchronous, active-low
- exp_wr_en  in  1  push expected value (LOAD only)
- exp_wr_data  in  DATA_W  expected value
- arm  in  1  one-cycle pulse: LOAD->RUN, or DONE->LOAD
- mon_write  in  1  core data-write strobe
- mon_addr  in  ADDR_W  core data address
- mon_data  in  DATA_W  core store data
- mon_inst  in  DATA_W  instruction currently fetched
- state_o  out  2  00 LOAD, 01 RUN, 10 DONE
- done  out  1  run finished
- pass  out  1  verdict, valid when done
- match_cnt, mismatch_cnt  out  CNT_W  compare results (saturating)
- cycle_cnt  out  CNT_W  cycles spent in RUN (saturating)
- stall_cnt  out  CNT_W  stall episodes seen
- err_valid  out  1  sticky: first mismatch captured
- err_addr  out  ADDR_W; err_exp, err_act  out  DATA_W  first mismatch details
- flags  out  4  {timeout, underflow, leftover, exp_ovf}, sticky

Behaviour:
- Reset: state LOAD; all outputs, counters, flags, err_* zero; buffer empty; previous-instruction register zero.
- LOAD: exp_wr_en pushes one entry per cycle; push when full is dropped and sets exp_ovf. mon_* ignored. arm -> RUN next cycle; counters/flags/err cleared, buffer contents kept.
- RUN, per cycle: cycle_cnt++. All mon_* sampled on the same edge; comparison result registered, visible 1 cycle after the strobe edge.
- mon_write with mon_data==TERM_SIG: not compared, no pop; -> DONE. leftover set if buffer non-empty.
- Other mon_write: pop head; equal -> match_cnt++; unequal -> mismatch_cnt++, and if !err_valid capture mon_addr/head/mon_data, set err_valid. Write with empty buffer: underflow set, mismatch_cnt++, err captured with err_exp=0.
- Stall: run-length counter of cycles mon_inst == previous value; stall_cnt++ exactly once when the run length reaches STALL_LIMIT-1; resets on change. First RUN cycle compares against a reset-valued (zero) previous register.
- cycle_cnt reaching TIMEOUT with no termination -> timeout set, DONE.
- Termination and timeout in the same cycle: termination wins, timeout not set.
- DONE: done=1; counters frozen; pass = (mismatch_cnt==0) & !timeout & !underflow & !leftover & !exp_ovf. arm -> LOAD with buffer flushed. exp_wr_en ignored in RUN/DONE.
- arm in RUN is ignored. nrst asserted mid-run: immediate return to reset values.
- Counters saturate at all-ones; no wrap.

Decomposition:
- Package run_mon_pkg: state encoding (LOAD/RUN/DONE), flag bit indices, default TERM_SIG.
- Sub-module mon_exp_fifo: single-clock FIFO (push, pop, flush, full, empty, head), depth EXP_DEPTH, registered pointers with wrap bit.

Test Plan:
- Load 3 values A5A5_0001, 0000_0010, DEAD_BEEF; arm; core writes same values then FFFF_FFFF -> done, pass=1, match_cnt=3, mismatch_cnt=0.
- Same load; second write 0000_0011 at addr 0x14 -> mismatch_cnt=1, err_addr=0x14, err_exp=0x10, err_act=0x11, pass=0.
- Load 1 value, core writes 2 values, then terminate -> underflow=1, mismatch_cnt=1; and load 3, write 2, terminate -> leftover=1, pass=0.
- mon_inst held at 0x2002_0004 for 5 cycles with STALL_LIMIT=2 -> stall_cnt=1; two separate 2-cycle holds -> stall_cnt=2.
- TIMEOUT=100, no termination write -> timeout=1, done after cycle_cnt=100; termination on the timeout cycle -> timeout=0.
- Push EXP_DEPTH+1 values -> exp_ovf=1; nrst pulsed mid-RUN -> all outputs zero, state LOAD.
